// File: rtl/c16_pkg.sv
// Shared C16 definitions: PRG loader state encoding and the BASIC/KERNAL
// end-of-program pointer locations patched after a PRG download.
package c16_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        PTR
    } prg_state_t;

    // Lo-byte address of each end pointer; the hi byte lives at +1.
    localparam logic [15:0] PRG_PTR_ADDR [0:3] = '{16'h002D, 16'h002F, 16'h0031, 16'h00AE};

    localparam int PRG_HDR_LEN = 2;

endpackage

// File: rtl/prg_loader.sv
// PRG download sequencer: strips the load-address header, writes the payload to
// main RAM over a req/ack port, then patches the end-of-program pointers.
module prg_loader
    import c16_pkg::*;
#(
    parameter logic [7:0] PRG_INDEX = 8'd1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ram_req,
    input  logic        ram_ack,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    prg_state_t  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        wait_q, wait_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  ptr_idx_q, ptr_idx_d;
    logic        dl_q;

    logic        start;
    logic        acked;
    logic [15:0] ptr_addr;

    assign start    = ioctl_download & ~dl_q & (ioctl_index == PRG_INDEX);
    assign acked    = req_q & ram_ack;
    assign ptr_addr = PRG_PTR_ADDR[ptr_idx_q[2:1]] + {15'd0, ptr_idx_q[0]};

    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        req_d      = req_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        wait_d     = wait_q;
        done_d     = 1'b0;
        error_d    = error_q;
        ptr_idx_d  = ptr_idx_q;

        if (start) begin
            // A new PRG download wins over anything in flight, including a pending request.
            state_d   = HDR_LO;
            error_d   = 1'b0;
            addr_d    = '0;
            req_d     = 1'b0;
            wait_d    = 1'b0;
            ptr_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                HDR_LO: begin
                    if (ioctl_wr) begin
                        addr_d[7:0] = ioctl_dout;
                        state_d     = HDR_HI;
                    end else if (!ioctl_download) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                HDR_HI: begin
                    if (ioctl_wr) begin
                        addr_d[15:8] = ioctl_dout;
                        state_d      = DATA;
                    end else if (!ioctl_download) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (acked) begin
                        req_d  = 1'b0;
                        wait_d = 1'b0;
                        addr_d = addr_q + 16'd1;
                        if (addr_q == 16'hFFFF)
                            error_d = 1'b1;
                    end
                    if (ioctl_wr) begin
                        // A byte arriving while a write is outstanding is dropped.
                        if (req_q) begin
                            error_d = 1'b1;
                        end else begin
                            req_d      = 1'b1;
                            wait_d     = 1'b1;
                            ram_addr_d = addr_q;
                            ram_data_d = ioctl_dout;
                        end
                    end else if (!ioctl_download && !req_q) begin
                        state_d   = PTR;
                        ptr_idx_d = '0;
                    end
                end
                PTR: begin
                    if (acked) begin
                        req_d     = 1'b0;
                        ptr_idx_d = ptr_idx_q + 3'd1;
                        if (ptr_idx_q == 3'd7) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (!req_q) begin
                        req_d      = 1'b1;
                        ram_addr_d = ptr_addr;
                        ram_data_d = ptr_idx_q[0] ? addr_q[15:8] : addr_q[7:0];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            req_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            wait_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ptr_idx_q  <= '0;
            dl_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ptr_idx_q  <= ptr_idx_d;
            dl_q       <= ioctl_download;
        end
    end

    assign ioctl_wait = wait_q;
    assign ram_req    = req_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_prg_loader.sv
// Bench for prg_loader: a file-level model predicts every RAM write, the final
// error flag and done pulses; a per-cycle monitor checks the port against it.
module tb_prg_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        ram_req;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        busy;
    logic        done;
    logic        error;

    prg_loader #(.PRG_INDEX(8'd1)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_req        (ram_req),
        .ram_ack        (ram_ack),
        .ram_addr       (ram_addr),
        .ram_data       (ram_data),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        bit          is_data;
    } wr_t;

    int total = 0;
    int bad   = 0;

    wr_t         exp_q[$];
    logic [15:0] log_a[$];
    logic [7:0]  log_d[$];
    bit          exp_err = 1'b0;
    int          exp_done = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          first_ptr_cyc = 0;
    int          ptr_seen = 0;
    int          ack_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // File-level model: payload lands at load+i, pointers get the wrapped end address.
    task automatic model_file(input logic [7:0] idx, input bytes_t b);
        logic [15:0] pa [8];
        logic [15:0] load;
        logic [15:0] e;
        wr_t         w;
        int          p;
        pa = '{16'h002D, 16'h002E, 16'h002F, 16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
        log_a.delete();
        log_d.delete();
        ptr_seen      = 0;
        first_ptr_cyc = 0;
        if (idx != 8'd1) return;
        if (b.size() < 2) begin
            exp_err = 1'b1;
            return;
        end
        load = {b[1], b[0]};
        p    = b.size() - 2;
        for (int i = 0; i < p; i++) begin
            w.a = 16'(int'(load) + i);
            w.d = b[i + 2];
            w.is_data = 1'b1;
            exp_q.push_back(w);
        end
        e       = 16'(int'(load) + p);
        exp_err = (int'(load) + p) > 65535;
        for (int i = 0; i < 8; i++) begin
            w.a = pa[i];
            w.d = (i % 2 == 1) ? e[15:8] : e[7:0];
            w.is_data = 1'b0;
            exp_q.push_back(w);
        end
        exp_done++;
    endtask

    // RAM responder: tied-high ack, or ack after ack_delay cycles of request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ack_delay == 0) begin
                ram_ack = 1'b1;
            end else begin
                ram_ack = 1'b0;
                if (ram_req) begin
                    cnt++;
                    if (cnt > ack_delay) begin
                        ram_ack = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Per-cycle monitor, sampled on the falling edge.
    logic        prev_pend = 1'b0;
    logic        prev_acked = 1'b0;
    logic [15:0] prev_a = '0;
    logic [7:0]  prev_d = '0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_pend  = 1'b0;
            prev_acked = 1'b0;
        end else begin
            cyc++;
            if (prev_pend && ram_req) begin
                check("addr_stable", ram_addr, prev_a);
                check("data_stable", ram_data, prev_d);
            end
            if (prev_acked)
                check("req_gap", ram_req, 0);
            if (ram_req) begin
                if (exp_q.size() == 0)
                    check("unexpected_req", ram_req, 0);
                else
                    check("wait_during_req", ioctl_wait, exp_q[0].is_data);
            end else begin
                check("wait_without_req", ioctl_wait, 0);
            end
            if (ram_req && ram_ack) begin
                log_a.push_back(ram_addr);
                log_d.push_back(ram_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", ram_addr, 32'hDEAD);
                end else begin
                    check("write_addr", ram_addr, exp_q[0].a);
                    check("write_data", ram_data, exp_q[0].d);
                    if (!exp_q[0].is_data) begin
                        if (ptr_seen == 0) first_ptr_cyc = cyc;
                        ptr_seen++;
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_pend  = ram_req & ~ram_ack;
            prev_acked = ram_req & ram_ack;
            prev_a     = ram_addr;
            prev_d     = ram_data;
        end
    end

    task automatic start_dl(input logic [7:0] idx, input bytes_t b);
        int k;
        model_file(idx, b);
        @(posedge clk_sys); #1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        if (idx == 8'd1) begin
            check("busy_at_start", busy, 1);
            check("error_cleared", error, 0);
        end else begin
            check("busy_ignored", busy, 0);
        end
        foreach (b[i]) begin
            ioctl_dout = b[i];
            ioctl_wr   = 1'b1;
            @(posedge clk_sys); #1;
            ioctl_wr   = 1'b0;
            @(posedge clk_sys); #1;
            k = 0;
            while (ioctl_wait && k < 200) begin
                @(posedge clk_sys); #1;
                k++;
            end
            if (k >= 200) check("wait_timeout", ioctl_wait, 0);
        end
        ioctl_download = 1'b0;
    endtask

    task automatic finish_dl();
        int k;
        k = 0;
        while (busy && k < 1000) begin
            @(posedge clk_sys); #1;
            k++;
        end
        check("busy_timeout", busy, 0);
        repeat (3) @(posedge clk_sys);
        #1;
        check("done_count", done_cnt, exp_done);
        check("error_flag", error, exp_err);
        check("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        bytes_t f;
        int     k;

        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_req", ram_req, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;

        // Basic file, ack tied high.
        ack_delay = 0;
        f = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        start_dl(8'd1, f);
        finish_dl();
        check("t1_nwrites", log_a.size(), 11);
        check("t1_first_addr", log_a[0], 16'h1001);
        check("t1_first_data", log_d[0], 8'hAA);
        check("t1_ptr0_addr", log_a[3], 16'h002D);
        check("t1_ptr0_data", log_d[3], 8'h04);
        check("t1_last_addr", log_a[10], 16'h00AF);
        check("t1_last_data", log_d[10], 8'h10);
        check("t1_ptr_span", done_cyc - first_ptr_cyc, 15);

        // Same file with slow acks.
        ack_delay = 5;
        start_dl(8'd1, f);
        finish_dl();
        check("t2_nwrites", log_a.size(), 11);

        // One-byte file: error, no writes, no done.
        ack_delay = 0;
        f = '{8'h00};
        start_dl(8'd1, f);
        finish_dl();
        check("t3_nwrites", log_a.size(), 0);

        // Header-only file; also clears the previous error.
        f = '{8'h00, 8'h20};
        start_dl(8'd1, f);
        finish_dl();
        check("t4_nwrites", log_a.size(), 8);
        check("t4_ptr_hi_addr", log_a[1], 16'h002E);
        check("t4_ptr_hi_data", log_d[1], 8'h20);

        // Load across the top of memory.
        f = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
        start_dl(8'd1, f);
        finish_dl();
        check("t5_wrap_addr", log_a[2], 16'h0000);
        check("t5_ptr_lo", log_d[4], 8'h02);
        check("t5_error", error, 1);

        // Reset during the third pointer write.
        ack_delay = 5;
        f = '{8'h00, 8'h30, 8'h5A};
        start_dl(8'd1, f);
        k = 0;
        while (!(ptr_seen == 2 && ram_req) && k < 500) begin
            @(posedge clk_sys); #1;
            k++;
        end
        check("t6_reach_ptr3", ptr_seen, 2);
        reset_n = 1'b0;
        #1;
        check("t6_req", ram_req, 0);
        check("t6_addr", ram_addr, 0);
        check("t6_data", ram_data, 0);
        check("t6_wait", ioctl_wait, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_error", error, 0);
        exp_q.delete();
        exp_err  = 1'b0;
        exp_done = done_cnt;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;

        // Foreign download index: no activity at all.
        ack_delay = 0;
        f = '{8'h00, 8'h40, 8'h77, 8'h88};
        start_dl(8'd2, f);
        finish_dl();
        check("t7_nwrites", log_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
